logical_tile_fabric_regbank_param: RTL and testbench
====================================================

# logical_tile_fabric_regbank_param

Parametrised register/output stage for the physical-mode fabric of the CLB logic element. It generalises the fixed two-output fabric to `NUM_CH` channels. Each channel has:

- a flip-flop with asynchronous reset, enable and scan;
- a configurable output select between combinational and registered data;
- an enable-bypass bit.

Configuration bits are loaded through the shared `ccff_head`/`ccff_tail` chain. A counter reports when a complete configuration frame has been shifted in.

## Interface
Parameters:
- `NUM_CH`, default 2: number of channels. Legal range 1..16.
- `CFG_LEN`, default `2*NUM_CH`: configuration bits in the chain. Derived; do not override.

Ports:
- `fabric_clk`, input, 1: the single clock. It drives the user flip-flops, the configuration chain and the counter.
- `fabric_reset`, input, 1: asynchronous, active-high reset.
- `config_enable`, input, 1: configuration shift mode.
- `ccff_head`, input, 1: configuration chain serial input.
- `fabric_d`, input, `NUM_CH`: combinational data from `frac_logic` outputs.
- `fabric_enable`, input, 1: flip-flop clock enable.
- `fabric_sc_in`, input, 1: scan chain serial input.
- `fabric_sc_mode`, input, 1: scan shift mode.
- `fabric_out`, output, `NUM_CH`: channel outputs.
- `fabric_sc_out`, output, 1: scan chain serial output.
- `ccff_tail`, output, 1: configuration chain serial output.
- `cfg_valid`, output, 1: full configuration frame loaded.

## Operation
State:
- `q[NUM_CH]`: user flip-flops.
- `cfg[CFG_LEN]`: configuration shift register.
- `cfg_cnt`: saturating counter, `$clog2(CFG_LEN+1)` bits.
- `cfg_en_d`: registered copy of `config_enable`.

Configuration map:
- `cfg[2i]` = `sel_i` (0 = combinational, 1 = registered).
- `cfg[2i+1]` = `byp_i` (1 = ignore `fabric_enable`).

Configuration chain:
- When `config_enable`=1: `cfg[0]` <= `ccff_head` and `cfg[k]` <= `cfg[k-1]`.
- `ccff_tail` = `cfg[CFG_LEN-1]`. The first bit shifted in therefore lands in `cfg[CFG_LEN-1]`.
- When `config_enable`=0, `cfg` holds.

Flip-flop update, highest priority first:
1. `config_enable`=1: all `q` hold.
2. `fabric_sc_mode`=1: scan shift. `q[0]` <= `fabric_sc_in`, `q[i]` <= `q[i-1]`. `fabric_enable` is ignored.
3. `fabric_enable`=1 or `byp_i`=1: `q[i]` <= `fabric_d[i]`.
4. Otherwise `q[i]` holds.

Outputs:
- `fabric_out[i]` = 0 while `config_enable`=1. Otherwise it is `sel_i` ? `q[i]` : `fabric_d[i]`, purely combinational.
- `fabric_sc_out` = `q[NUM_CH-1]`.

Frame counter:
- When `config_enable`=1 and `cfg_en_d`=0 (start of a new frame), `cfg_cnt` <= 1.
- When `config_enable`=1 and `cfg_en_d`=1, `cfg_cnt` <= min(`cfg_cnt`+1, `CFG_LEN`).
- When `config_enable`=0, `cfg_cnt` holds.
- `cfg_valid` = (`cfg_cnt`==`CFG_LEN`) && !`config_enable`.

## Timing
- Reset: asserting `fabric_reset` immediately clears `q`, `cfg`, `cfg_cnt` and `cfg_en_d` to 0. Resulting output values:
  - `fabric_out` = `fabric_d` (all channels combinational), or 0 if `config_enable`=1.
  - `fabric_sc_out` = 0, `ccff_tail` = 0, `cfg_valid` = 0.
- Reset mid-frame discards partial configuration. A new frame must restart from bit 0.
- Latency:
  - Registered path: `fabric_d` to `fabric_out` in 1 cycle.
  - Combinational path: 0 cycles.
  - Scan: `fabric_sc_in` to `fabric_sc_out` in `NUM_CH` cycles.
  - Configuration: `ccff_head` to `ccff_tail` in `CFG_LEN` cycles.
- A frame shorter than `CFG_LEN` leaves `cfg_valid`=0.
- A frame longer than `CFG_LEN` saturates `cfg_cnt`. The valid state is the last `CFG_LEN` bits shifted in.
- Dropping `config_enable` for one cycle mid-frame and re-asserting it restarts the count at 1. The `cfg` contents keep shifting.
- If `config_enable` and `fabric_sc_mode` are both 1, configuration wins and `q` holds.
- If `fabric_sc_mode` and `fabric_enable` are both 1, scan wins.

## Configuration
- Macro `FABRIC_REGBANK_SCAN_EN`.
- Defined: scan behaviour as described above.
- Undefined:
  - `fabric_sc_mode` and `fabric_sc_in` are ignored.
  - `fabric_sc_out` is tied to 0.
  - Priority 2 is removed.
  - Port list is unchanged.

## Test plan
- Reset release, `NUM_CH`=4, `fabric_d`=4'b1010 -> `fabric_out`=4'b1010, `cfg_valid`=0, `ccff_tail`=0.
- Shift 8 bits (final `cfg`=8'b01010101, all `sel`=1, `byp`=0), `config_enable` high for exactly 8 cycles:
  - `fabric_out`=0 during the shift; `cfg_valid`=1 afterwards.
  - With `fabric_enable`=1 and `fabric_d`=4'hC -> `fabric_out`=4'hC one cycle later.
  - With `fabric_enable`=0 -> `fabric_out` holds.
- `byp_0`=1, `fabric_enable`=0, `fabric_d[0]` toggling -> `q[0]` follows with 1-cycle lag; other channels hold.
- Scan (macro defined, `NUM_CH`=4): `fabric_sc_mode`=1, `fabric_sc_in` = 1,0,1,1 -> `fabric_sc_out` = 1,0,1,1 starting on the 4th cycle. With the macro undefined, `fabric_sc_out` stays 0.
- Frame interrupted after 5 of 8 bits, then reset -> `cfg_valid`=0 and `ccff_tail`=0. A subsequent 9-bit frame -> `cfg_valid`=1 and `cfg` holds the last 8 bits shifted in.

Source files
------------

// File: rtl/logical_tile_fabric_regbank_param.sv
// ---------------------------------------------------------------------------
// logical_tile_fabric_regbank_param
//
// Parametrised register/output stage for the physical-mode CLB fabric.
// Each of NUM_CH channels has a user flip-flop (async reset, enable, scan),
// an output select between combinational and registered data, and an
// enable-bypass bit. Configuration bits arrive serially on ccff_head and
// leave on ccff_tail. A saturating counter flags a complete frame.
//
// Configuration map: cfg[2i] = sel_i (1 = registered), cfg[2i+1] = byp_i.
//
// Build option: define FABRIC_REGBANK_SCAN_EN to enable the scan chain.
// Without it, fabric_sc_mode/fabric_sc_in are ignored and fabric_sc_out
// is tied to 0. The port list is the same in both builds.
//
// Ports:
//   fabric_clk      in   clock for user FFs, config chain and counter
//   fabric_reset    in   asynchronous active-high reset
//   config_enable   in   configuration shift mode
//   ccff_head       in   configuration chain serial input
//   fabric_d        in   [NUM_CH] combinational data from frac_logic
//   fabric_enable   in   flip-flop clock enable
//   fabric_sc_in    in   scan chain serial input
//   fabric_sc_mode  in   scan shift mode
//   fabric_out      out  [NUM_CH] channel outputs
//   fabric_sc_out   out  scan chain serial output
//   ccff_tail       out  configuration chain serial output
//   cfg_valid       out  full configuration frame loaded
// ---------------------------------------------------------------------------
module logical_tile_fabric_regbank_param #(
    parameter int NUM_CH  = 2,
    parameter int CFG_LEN = 2 * NUM_CH
) (
    input  logic              fabric_clk,
    input  logic              fabric_reset,
    input  logic              config_enable,
    input  logic              ccff_head,
    input  logic [NUM_CH-1:0] fabric_d,
    input  logic              fabric_enable,
    input  logic              fabric_sc_in,
    input  logic              fabric_sc_mode,
    output logic [NUM_CH-1:0] fabric_out,
    output logic              fabric_sc_out,
    output logic              ccff_tail,
    output logic              cfg_valid
);

    localparam int CNT_W = $clog2(CFG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0]  q_r;
    logic [NUM_CH-1:0]  q_nxt_s;
    logic [CFG_LEN-1:0] cfg_r;
    logic [CNT_W-1:0]   cfg_cnt_r;
    logic               cfg_en_d_r;
    logic [NUM_CH-1:0]  sel_s;
    logic [NUM_CH-1:0]  byp_s;

`ifndef FABRIC_REGBANK_SCAN_EN
    // Scan inputs have no function in this build; gathered here so they
    // are visibly consumed.
    logic unused_scan_s;
    assign unused_scan_s = fabric_sc_mode ^ fabric_sc_in;
`endif

    // Unpack the interleaved sel/byp bits from the configuration register.
    always_comb begin
        sel_s = {NUM_CH{1'b0}};
        byp_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sel_s[i] = cfg_r[2*i];
            byp_s[i] = cfg_r[2*i+1];
        end
    end

    // Next-state for the user flip-flops: config hold > scan > enable/bypass.
    always_comb begin
        q_nxt_s = q_r;
        if (config_enable) begin
            q_nxt_s = q_r;
        end
`ifdef FABRIC_REGBANK_SCAN_EN
        else if (fabric_sc_mode) begin
            q_nxt_s[0] = fabric_sc_in;
            for (int i = 1; i < NUM_CH; i++) begin
                q_nxt_s[i] = q_r[i-1];
            end
        end
`endif
        else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fabric_enable || byp_s[i]) begin
                    q_nxt_s[i] = fabric_d[i];
                end else begin
                    q_nxt_s[i] = q_r[i];
                end
            end
        end
    end

    // User flip-flop register.
    always_ff @(posedge fabric_clk or posedge fabric_reset) begin
        if (fabric_reset) begin
            q_r <= {NUM_CH{1'b0}};
        end else begin
            q_r <= q_nxt_s;
        end
    end

    // Configuration shift register: new bits enter at cfg[0].
    always_ff @(posedge fabric_clk or posedge fabric_reset) begin
        if (fabric_reset) begin
            cfg_r <= {CFG_LEN{1'b0}};
        end else if (config_enable) begin
            cfg_r <= {cfg_r[CFG_LEN-2:0], ccff_head};
        end else begin
            cfg_r <= cfg_r;
        end
    end

    // Frame counter: restarts at 1 on a rising config_enable, saturates at
    // CFG_LEN, and holds while configuration is idle.
    always_ff @(posedge fabric_clk or posedge fabric_reset) begin
        if (fabric_reset) begin
            cfg_cnt_r  <= {CNT_W{1'b0}};
            cfg_en_d_r <= 1'b0;
        end else begin
            cfg_en_d_r <= config_enable;
            if (config_enable) begin
                if (!cfg_en_d_r) begin
                    cfg_cnt_r <= CNT_ONE;
                end else if (cfg_cnt_r != CNT_MAX) begin
                    cfg_cnt_r <= cfg_cnt_r + CNT_ONE;
                end else begin
                    cfg_cnt_r <= cfg_cnt_r;
                end
            end else begin
                cfg_cnt_r <= cfg_cnt_r;
            end
        end
    end

    // Channel output mux; outputs are forced low while the chain is shifting
    // so half-loaded configuration never reaches the routing.
    always_comb begin
        fabric_out = {NUM_CH{1'b0}};
        if (config_enable) begin
            fabric_out = {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_s[i]) begin
                    fabric_out[i] = q_r[i];
                end else begin
                    fabric_out[i] = fabric_d[i];
                end
            end
        end
    end

`ifdef FABRIC_REGBANK_SCAN_EN
    assign fabric_sc_out = q_r[NUM_CH-1];
`else
    assign fabric_sc_out = 1'b0;
`endif
    assign ccff_tail = cfg_r[CFG_LEN-1];
    assign cfg_valid = (cfg_cnt_r == CNT_MAX) && !config_enable;

endmodule

// File: tb/tb_logical_tile_fabric_regbank_param.sv
module tb_logical_tile_fabric_regbank_param;

    localparam int N = 4;
    localparam int L = 2 * N;
`ifdef FABRIC_REGBANK_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ce = 1'b0;
    logic         head = 1'b0;
    logic [N-1:0] d = '0;
    logic         en = 1'b0;
    logic         sc_in = 1'b0;
    logic         sc_mode = 1'b0;
    logic [N-1:0] out;
    logic         sc_out;
    logic         tail;
    logic         valid;

    always #5 clk = ~clk;

    logical_tile_fabric_regbank_param #(.NUM_CH(N)) dut (
        .fabric_clk    (clk),
        .fabric_reset  (rst),
        .config_enable (ce),
        .ccff_head     (head),
        .fabric_d      (d),
        .fabric_enable (en),
        .fabric_sc_in  (sc_in),
        .fabric_sc_mode(sc_mode),
        .fabric_out    (out),
        .fabric_sc_out (sc_out),
        .ccff_tail     (tail),
        .cfg_valid     (valid)
    );

    typedef struct {
        logic [N-1:0] out;
        logic         sc_out;
        logic         tail;
        logic         valid;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // ---------------- reference model ----------------
    // Flip-flop contents, history of configuration bits (newest at back,
    // so cfg[k] is the bit shifted in k+1 shifts ago), and length of the
    // current run of consecutive config_enable cycles.
    bit m_q[N];
    bit m_hist[$];
    int m_run;
    bit m_prev_ce;

    function automatic bit m_cfg(int k);
        return m_hist[m_hist.size() - 1 - k];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_q[i] = 1'b0;
        m_hist.delete();
        for (int k = 0; k < L; k++) m_hist.push_back(1'b0);
        m_run = 0;
        m_prev_ce = 1'b0;
    endtask

    function automatic exp_t m_expect(bit c, logic [N-1:0] dd, string tag);
        exp_t e;
        e.tag = tag;
        e.out = '0;
        if (!c) begin
            for (int i = 0; i < N; i++)
                e.out[i] = m_cfg(2 * i) ? m_q[i] : dd[i];
        end
        e.sc_out = SCAN ? m_q[N-1] : 1'b0;
        e.tail   = m_cfg(L - 1);
        e.valid  = (m_run >= L) && !c;
        return e;
    endfunction

    task automatic model_clock(bit c, bit h, bit e, logic [N-1:0] dd, bit sm, bit si);
        bit nq[N];
        for (int i = 0; i < N; i++) nq[i] = m_q[i];
        if (c) begin
            // configuration owns the cycle: q holds
        end else if (SCAN && sm) begin
            nq[0] = si;
            for (int i = 1; i < N; i++) nq[i] = m_q[i-1];
        end else begin
            for (int i = 0; i < N; i++)
                if (e || m_cfg(2 * i + 1)) nq[i] = dd[i];
        end
        for (int i = 0; i < N; i++) m_q[i] = nq[i];
        if (c) begin
            m_hist.push_back(h);
            void'(m_hist.pop_front());
            m_run = m_prev_ce ? ((m_run < L) ? m_run + 1 : L) : 1;
        end
        m_prev_ce = c;
    endtask

    // ---------------- stimulus ----------------
    // Inputs change 1 time unit after the rising edge; the expectation for
    // this cycle is queued and the monitor compares on the falling edge.
    task automatic step(bit c, bit h, bit e, logic [N-1:0] dd, bit sm, bit si, string tag);
        ce = c; head = h; en = e; d = dd; sc_mode = sm; sc_in = si;
        exp_q.push_back(m_expect(c, dd, tag));
        @(posedge clk);
        model_clock(c, h, e, dd, sm, si);
        #1;
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        model_reset();
        exp_q.push_back(m_expect(ce, d, tag));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Shift a frame; bits[0] is shifted first.
    task automatic shift_frame(logic [15:0] bits, int nbits, string tag);
        for (int k = 0; k < nbits; k++)
            step(1'b1, bits[k], en, d, 1'b0, 1'b0, tag);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".out"}, out, e.out);
            chk({e.tag, ".sc_out"}, {{(N-1){1'b0}}, sc_out}, {{(N-1){1'b0}}, e.sc_out});
            chk({e.tag, ".tail"}, {{(N-1){1'b0}}, tail}, {{(N-1){1'b0}}, e.tail});
            chk({e.tag, ".valid"}, {{(N-1){1'b0}}, valid}, {{(N-1){1'b0}}, e.valid});
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] frame;
        d = 4'b1010;
        @(posedge clk);
        #1;
        do_reset("reset");
        step(1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, "post_reset");

        // cfg = 8'b01010101: shifted MSB (cfg[7]) first.
        frame = 16'h00AA;
        shift_frame(frame, L, "shift_sel");
        step(1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, "load_c");
        step(1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, "hold_c");
        step(1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, "hold_c2");

        // cfg = 8'b01010111: byp_0 set, all sel set.
        frame = 16'h00EA;
        shift_frame(frame, L, "shift_byp");
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b0, 1'b0, {3'b101, k[0]}, 1'b0, 1'b0, "byp_toggle");

        // Scan pattern 1,0,1,1 then flush.
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, "scan");
        step(1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, "scan");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "scan");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "scan");
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "scan_flush");
        step(1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, "cfg_beats_scan");

        // Interrupted frame, reset, then 9-bit frame.
        do_reset("reset2");
        frame = 16'h001F;
        shift_frame(frame, 5, "partial");
        step(1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, "partial_idle");
        do_reset("reset_mid");
        step(1'b0, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, "after_reset_mid");
        frame = 16'h0155;
        shift_frame(frame, 9, "frame9");
        step(1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, "frame9_use");
        step(1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, "frame9_use");

        // Drop config_enable one cycle mid-frame.
        shift_frame(16'h0007, 3, "gap_a");
        step(1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, "gap");
        shift_frame(16'h0005, 6, "gap_b");
        step(1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, "gap_end");

        // Randomized traffic with bursty configuration and rare resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_reset");
            end else begin
                bit c;
                c = (m_prev_ce) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
                step(c, 1'($urandom), 1'($urandom), 4'($urandom),
                     ($urandom_range(0, 3) == 0), 1'($urandom), "random");
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
